fpga_flash_reader: RTL and testbench

- Serial-flash read controller that sequences the FPGA configuration flash (EPCS/ASMI-style, SPI mode 0) on behalf of the STM32 parallel-bus interface.
- The bus interface latches a start-sector byte and holds enable high. The block issues the READ command and a 24-bit address, then streams bytes one at a time.
- Each next byte is fetched only when the bus interface pulses continue_read.
- busy reports whether data_out holds a fresh, valid byte.

---
 rtl/fpga_flash_reader.sv | 192 +++++++++++++++++++
 tb/tb_fpga_flash_reader.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpga_flash_reader.sv
// fpga_flash_reader
//   Serial-flash read controller (EPCS/ASMI style, SPI mode 0) used by the
//   STM32 parallel-bus interface to stream bytes out of the configuration
//   flash. On the first cycle enable is high it latches cmd_byte as the
//   start sector and clocks out READ_CMD plus the 24-bit address
//   {cmd_byte, ADDR_LOW}. It then reads one byte and waits in READY. Each
//   continue_read pulse in READY fetches the next sequential byte.
//   Dropping enable aborts the transfer at once.
//
// Ports
//   clk_in        system clock, rising edge
//   rst_n         asynchronous active-low reset
//   cmd_byte      start-sector byte, sampled on the start cycle only
//   enable        level, high = transaction active, low = abort / idle
//   continue_read one-cycle request for the next byte (honoured in READY only)
//   data_out      last complete byte read from flash
//   busy          1 = data_out stale / fetch in progress, 0 = byte ready
//   rd_count      bytes delivered in the current transaction (wraps)
//   flash_ncs     flash chip select, active low
//   flash_dclk    SPI clock, idles low
//   flash_asdo    serial data to flash (MOSI)
//   flash_data0   serial data from flash (MISO)

module fpga_flash_reader #(
  parameter int          CLK_DIV  = 2,
  parameter logic [7:0]  READ_CMD = 8'h03,
  parameter logic [15:0] ADDR_LOW = 16'h0000
) (
  input  logic        clk_in,
  input  logic        rst_n,
  input  logic [7:0]  cmd_byte,
  input  logic        enable,
  input  logic        continue_read,
  output logic [7:0]  data_out,
  output logic        busy,
  output logic [15:0] rd_count,
  output logic        flash_ncs,
  output logic        flash_dclk,
  output logic        flash_asdo,
  input  logic        flash_data0
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    READY
  } state_t;

  state_t             state, state_n;
  logic [DIV_W-1:0]   div_cnt;
  logic [4:0]         bit_cnt;
  logic [31:0]        tx_sr;
  logic [7:0]         rx_sr;
  logic               dclk_q;

  // Timing helpers shared by the next-state and datapath logic.
  logic div_tc;      // end of one SCLK half-period
  logic data_done;   // all 8 data bits clocked, byte waiting to be published
  logic shifting;    // SPI clock is running this cycle
  logic fall_edge;   // dclk falls this cycle, current bit ends
  logic last_bit;    // ending bit is the last one of CMD or ADDR

  assign div_tc    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign data_done = (state == DATA) && (bit_cnt == 5'd8);
  assign shifting  = (state == CMD) || (state == ADDR) ||
                     ((state == DATA) && !data_done);
  assign fall_edge = shifting && div_tc && dclk_q;
  assign last_bit  = ((state == CMD)  && (bit_cnt == 5'd7)) ||
                     ((state == ADDR) && (bit_cnt == 5'd23));

  // ---------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------
  // NOTE: sequential state is assigned with <= so every register samples
  // the pre-edge values of its peers; blocking '=' here would create
  // order-dependent simulation and mismatch synthesis.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // ---------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------
  // NOTE: state_n gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    state_n = state;
    if (state != IDLE && !enable) begin
      // Abort has priority over everything, including continue_read.
      state_n = IDLE;
    end else begin
      case (state)
        IDLE:    if (enable)                state_n = CMD;
        CMD:     if (fall_edge && last_bit) state_n = ADDR;
        ADDR:    if (fall_edge && last_bit) state_n = DATA;
        DATA:    if (data_done)             state_n = READY;
        READY:   if (continue_read)         state_n = DATA;
        default:                            state_n = IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Outputs decoded from state
  // ---------------------------------------------------------------------
  always_comb begin
    flash_ncs  = (state == IDLE);
    busy       = (state != READY);
    flash_asdo = 1'b0;
    if (state == CMD || state == ADDR) flash_asdo = tx_sr[31];
  end

  assign flash_dclk = dclk_q;

  // ---------------------------------------------------------------------
  // Datapath: SPI clock divider, bit counter, shift registers, result
  // ---------------------------------------------------------------------
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      tx_sr    <= '0;
      rx_sr    <= '0;
      dclk_q   <= 1'b0;
      data_out <= 8'h00;
      rd_count <= 16'h0000;
    end else if (state != IDLE && !enable) begin
      // Abort: park the bus. A partial byte in rx_sr is simply dropped, and
      // data_out / rd_count keep their last values.
      div_cnt <= '0;
      bit_cnt <= '0;
      dclk_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            tx_sr    <= {READ_CMD, cmd_byte, ADDR_LOW};
            bit_cnt  <= '0;
            div_cnt  <= '0;
            dclk_q   <= 1'b0;
            rd_count <= 16'h0000;
          end
        end
        CMD, ADDR, DATA: begin
          if (shifting) begin
            if (div_tc) begin
              div_cnt <= '0;
              dclk_q  <= !dclk_q;
              if (!dclk_q) begin
                // Rising edge: capture MISO in the same cycle.
                rx_sr <= {rx_sr[6:0], flash_data0};
              end else begin
                // Falling edge: advance MOSI, restart count at a phase change.
                tx_sr   <= {tx_sr[30:0], 1'b0};
                bit_cnt <= last_bit ? 5'd0 : bit_cnt + 5'd1;
              end
            end else begin
              div_cnt <= div_cnt + 1'b1;
            end
          end else begin
            // data_done: publish the byte; state moves to READY together.
            data_out <= rx_sr;
            rd_count <= rd_count + 16'd1;
            bit_cnt  <= '0;
          end
        end
        READY: begin
          if (continue_read) begin
            // Continuous read: the flash keeps streaming, so only the
            // 8 data bits are clocked again.
            bit_cnt <= '0;
            div_cnt <= '0;
          end
        end
        default: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          dclk_q  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fpga_flash_reader.sv
// tb_fpga_flash_reader
//   Directed bench for fpga_flash_reader at CLK_DIV=2. A behavioural flash
//   model serves bytes from flash_bytes[] after the 32-bit command/address
//   frame. Stimulus pushes expected frames and bytes into queues. Separate
//   monitors pop and compare them when the DUT completes a frame on MOSI or
//   drops busy.

module tb_fpga_flash_reader;

  localparam int CLK_DIV   = 2;
  localparam int FIRST_LAT = 1 + 80 * CLK_DIV;
  localparam int NEXT_LAT  = 1 + 16 * CLK_DIV;

  logic        clk_in;
  logic        rst_n;
  logic [7:0]  cmd_byte;
  logic        enable;
  logic        continue_read;
  logic [7:0]  data_out;
  logic        busy;
  logic [15:0] rd_count;
  logic        flash_ncs;
  logic        flash_dclk;
  logic        flash_asdo;
  logic        flash_data0;

  fpga_flash_reader #(
    .CLK_DIV  (CLK_DIV),
    .READ_CMD (8'h03),
    .ADDR_LOW (16'h0000)
  ) u_dut (
    .clk_in        (clk_in),
    .rst_n         (rst_n),
    .cmd_byte      (cmd_byte),
    .enable        (enable),
    .continue_read (continue_read),
    .data_out      (data_out),
    .busy          (busy),
    .rd_count      (rd_count),
    .flash_ncs     (flash_ncs),
    .flash_dclk    (flash_dclk),
    .flash_asdo    (flash_asdo),
    .flash_data0   (flash_data0)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc++;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_fail(input string name);
    tests++;
    fails++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Scoreboard queues
  typedef struct {
    logic [7:0]  data;
    logic [15:0] count;
    int          cycle;
  } exp_byte_t;

  exp_byte_t   byte_q[$];
  logic [31:0] frame_q[$];

  // Flash model: drives the next data bit after each falling dclk once the
  // 32-bit command/address frame has been clocked in.
  logic [7:0] flash_bytes [0:7];
  int fall_cnt = 0;
  int model_idx;
  initial flash_data0 = 1'b0;
  always @(negedge flash_dclk or posedge flash_ncs) begin
    if (flash_ncs) begin
      fall_cnt = 0;
    end else begin
      fall_cnt++;
      if (fall_cnt >= 32) begin
        model_idx   = fall_cnt - 32;
        flash_data0 = flash_bytes[(model_idx / 8) % 8][7 - (model_idx % 8)];
      end
    end
  end

  // MOSI monitor: collect the frame on rising dclk, then require asdo=0.
  int          rise_cnt = 0;
  int          total_rises = 0;
  logic [31:0] mosi_sr = '0;

  always @(posedge flash_dclk) begin
    total_rises++;
    check("ncs_low_at_dclk_rise", flash_ncs, 0);
  end

  always @(posedge flash_dclk or posedge flash_ncs) begin
    if (flash_ncs) begin
      rise_cnt = 0;
      mosi_sr  = '0;
    end else begin
      rise_cnt++;
      if (rise_cnt <= 32) begin
        mosi_sr = {mosi_sr[30:0], flash_asdo};
        if (rise_cnt == 32) begin
          if (frame_q.size() == 0) flag_fail("unexpected_frame");
          else check("cmd_addr_frame", mosi_sr, frame_q.pop_front());
        end
      end else begin
        check("asdo_zero_in_data", flash_asdo, 0);
      end
    end
  end

  // Byte monitor: every busy 1->0 transition must match a queued byte.
  logic      prev_busy = 1'b1;
  exp_byte_t mon_e;
  always @(negedge clk_in) begin
    if (rst_n === 1'b1 && prev_busy && !busy) begin
      if (byte_q.size() == 0) begin
        flag_fail("unexpected_byte");
      end else begin
        mon_e = byte_q.pop_front();
        check("data_out", data_out, mon_e.data);
        check("rd_count", rd_count, mon_e.count);
        check("busy_fall_cycle", cyc, mon_e.cycle);
      end
    end
    prev_busy = busy;
  end

  // Stimulus helpers (called at a falling clk edge)
  task automatic start_txn(input logic [7:0] cmd, input logic [7:0] first,
                           input bit push_frame, input bit push_byte);
    exp_byte_t e;
    flash_bytes[0] = first;
    enable   = 1'b1;
    cmd_byte = cmd;
    if (push_frame) frame_q.push_back({8'h03, cmd, 16'h0000});
    if (push_byte) begin
      e.data  = first;
      e.count = 16'd1;
      e.cycle = cyc + 1 + FIRST_LAT;
      byte_q.push_back(e);
    end
    @(negedge clk_in);
    cmd_byte = 8'hEE;   // later changes must not affect the address
  endtask

  task automatic pulse_continue(input logic [7:0] data, input logic [15:0] count,
                                input bit push_byte);
    exp_byte_t e;
    continue_read = 1'b1;
    if (push_byte) begin
      e.data  = data;
      e.count = count;
      e.cycle = cyc + 1 + NEXT_LAT;
      byte_q.push_back(e);
    end
    @(negedge clk_in);
    continue_read = 1'b0;
  endtask

  task automatic wait_busy_low(input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_in);
      if (!busy) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) flag_fail("timeout_waiting_busy_low");
  endtask

  task automatic wait_rise(input int n, input int max_cycles);
    bit seen = 1'b0;
    for (int i = 0; i < max_cycles; i++) begin
      @(negedge clk_in);
      if (rise_cnt >= n) begin
        seen = 1'b1;
        break;
      end
    end
    if (!seen) flag_fail("timeout_waiting_dclk_rise");
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  int rises_before;

  initial begin
    rst_n         = 1'b0;
    enable        = 1'b0;
    cmd_byte      = 8'h00;
    continue_read = 1'b0;
    for (int i = 0; i < 8; i++) flash_bytes[i] = 8'h00;

    // Reset state
    repeat (3) @(negedge clk_in);
    check("rst_ncs",      flash_ncs,  1);
    check("rst_dclk",     flash_dclk, 0);
    check("rst_asdo",     flash_asdo, 0);
    check("rst_busy",     busy,       1);
    check("rst_data_out", data_out,   8'h00);
    check("rst_rd_count", rd_count,   16'h0000);
    rst_n = 1'b1;
    @(negedge clk_in);

    // First transaction: sector 0x05, then three continuous reads
    flash_bytes[1] = 8'h11;
    flash_bytes[2] = 8'h22;
    flash_bytes[3] = 8'h33;
    start_txn(8'h05, 8'hA5, 1'b1, 1'b1);
    check("ncs_low_after_start", flash_ncs, 0);
    wait_busy_low(FIRST_LAT + 20);
    @(negedge clk_in);
    pulse_continue(8'h11, 16'd2, 1'b1);
    wait_busy_low(NEXT_LAT + 20);
    @(negedge clk_in);
    pulse_continue(8'h22, 16'd3, 1'b1);
    wait_busy_low(NEXT_LAT + 20);
    @(negedge clk_in);
    pulse_continue(8'h33, 16'd4, 1'b1);
    wait_busy_low(NEXT_LAT + 20);
    check("ready_ncs_low", flash_ncs, 0);
    check("ready_dclk_low", flash_dclk, 0);

    // Abort from READY keeps data_out and rd_count
    enable = 1'b0;
    @(negedge clk_in);
    check("abort_ready_busy", busy, 1);
    check("abort_ready_ncs", flash_ncs, 1);
    check("abort_ready_data_out", data_out, 8'h33);
    check("abort_ready_rd_count", rd_count, 16'd4);

    // continue_read in ADDR and in DATA is ignored: one byte only
    start_txn(8'h12, 8'h5A, 1'b1, 1'b1);
    repeat (39) @(negedge clk_in);
    pulse_continue(8'h00, 16'd0, 1'b0);     // lands in ADDR
    repeat (108) @(negedge clk_in);
    pulse_continue(8'h00, 16'd0, 1'b0);     // lands in the data byte
    wait_busy_low(FIRST_LAT);
    repeat (60) @(negedge clk_in);
    check("ignored_pulses_still_ready", busy, 0);
    check("ignored_pulses_rd_count", rd_count, 16'd1);

    // Abort on the 20th address bit, then restart with sector 0x7F
    enable = 1'b0;
    @(negedge clk_in);
    start_txn(8'h33, 8'h00, 1'b0, 1'b0);
    wait_rise(8 + 20, 200);
    enable = 1'b0;
    @(negedge clk_in);
    check("abort_addr_ncs",      flash_ncs,  1);
    check("abort_addr_dclk",     flash_dclk, 0);
    check("abort_addr_asdo",     flash_asdo, 0);
    check("abort_addr_busy",     busy,       1);
    check("abort_addr_data_out", data_out,   8'h5A);
    check("abort_addr_rd_count", rd_count,   16'd0);
    start_txn(8'h7F, 8'hC3, 1'b1, 1'b1);
    wait_busy_low(FIRST_LAT + 20);
    @(negedge clk_in);

    // enable low and continue_read high together: abort wins
    enable        = 1'b0;
    continue_read = 1'b1;
    @(negedge clk_in);
    continue_read = 1'b0;
    check("abort_vs_continue_busy", busy, 1);
    check("abort_vs_continue_ncs", flash_ncs, 1);
    rises_before = total_rises;
    repeat (40) @(negedge clk_in);
    check("abort_vs_continue_no_dclk", total_rises, rises_before);
    check("abort_vs_continue_data_out", data_out, 8'hC3);
    check("abort_vs_continue_rd_count", rd_count, 16'd1);

    // Asynchronous reset in the middle of a data byte
    start_txn(8'h44, 8'h99, 1'b1, 1'b0);
    repeat (139) @(negedge clk_in);
    check("mid_data_dclk_running", rise_cnt > 32, 1);
    #1 rst_n = 1'b0;
    #1;
    check("async_rst_ncs",      flash_ncs,  1);
    check("async_rst_dclk",     flash_dclk, 0);
    check("async_rst_busy",     busy,       1);
    check("async_rst_data_out", data_out,   8'h00);
    check("async_rst_rd_count", rd_count,   16'h0000);
    @(negedge clk_in);
    enable = 1'b0;
    rst_n  = 1'b1;
    repeat (5) @(negedge clk_in);

    check("frames_outstanding", frame_q.size(), 0);
    check("bytes_outstanding", byte_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
